// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next PC and runs the instruction-memory handshake.
// Optional macro PC_SEQ_MISALIGN_FAULT_EN turns misaligned redirects into a FAULT state.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_new,
    output logic            pc_en,
    input  logic            stall_f,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_misaligned
);

`ifdef PC_SEQ_MISALIGN_FAULT_EN
    typedef enum logic [2:0] {S_BOOT = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_HOLD = 3'd3, S_FAULT = 3'd4} state_t;
`else
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_HOLD = 2'd3} state_t;
`endif

    state_t          state_r, state_s;
    logic            pend_valid_r, pend_valid_s;
    logic            pend_trap_r, pend_trap_s;
    logic [XLEN-1:0] pend_target_r, pend_target_s;
    logic [XLEN-1:0] buf_instr_r, buf_instr_s;
    logic [XLEN-1:0] buf_pc_r, buf_pc_s;
    logic            eff_valid_s, eff_trap_s;
    logic [XLEN-1:0] eff_target_s, redir_target_s;
    logic            resolve_s, misaligned_s;
    logic            pc_en_s, imem_req_s, instr_valid_s;
    logic [XLEN-1:0] pc_new_s, instr_s, instr_pc_s;

`ifdef PC_SEQ_MISALIGN_FAULT_EN
    assign redir_target_s = redirect_target;
`else
    assign redir_target_s = redirect_target & ~(XLEN'(32'd3));
`endif

    // Merge incoming redirect with the pending one: trap wins, a redirect never displaces a trap.
    always_comb begin
        if (trap_valid) begin
            eff_valid_s  = 1'b1;
            eff_trap_s   = 1'b1;
            eff_target_s = trap_vector;
        end else if (redirect_valid && !(pend_valid_r && pend_trap_r)) begin
            eff_valid_s  = 1'b1;
            eff_trap_s   = 1'b0;
            eff_target_s = redir_target_s;
        end else begin
            eff_valid_s  = pend_valid_r;
            eff_trap_s   = pend_trap_r;
            eff_target_s = pend_target_r;
        end
    end

    // Next-state, PC policy and fetch outputs.
    always_comb begin
        state_s       = state_r;
        pend_valid_s  = pend_valid_r;
        pend_trap_s   = pend_trap_r;
        pend_target_s = pend_target_r;
        buf_instr_s   = buf_instr_r;
        buf_pc_s      = buf_pc_r;
        pc_en_s       = 1'b0;
        pc_new_s      = pc + XLEN'(32'd4);
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
        instr_s       = {XLEN{1'b0}};
        instr_pc_s    = {XLEN{1'b0}};
        misaligned_s  = 1'b0;
        resolve_s     = 1'b0;
        case (state_r)
            S_BOOT: begin
                pc_en_s      = 1'b1;
                pc_new_s     = RESET_VECTOR;
                pend_valid_s = 1'b0;
                state_s      = S_REQ;
            end
            S_REQ: begin
                imem_req_s    = 1'b1;
                pend_valid_s  = eff_valid_s;
                pend_trap_s   = eff_trap_s;
                pend_target_s = eff_target_s;
                if (imem_gnt) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (!imem_rvalid) begin
                    pend_valid_s  = eff_valid_s;
                    pend_trap_s   = eff_trap_s;
                    pend_target_s = eff_target_s;
                end else if (eff_valid_s) begin
                    resolve_s = 1'b1;
                end else if (!stall_f) begin
                    instr_valid_s = 1'b1;
                    instr_s       = imem_rdata;
                    instr_pc_s    = pc;
                    pc_en_s       = 1'b1;
                    state_s       = S_REQ;
                end else begin
                    buf_instr_s = imem_rdata;
                    buf_pc_s    = pc;
                    state_s     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (eff_valid_s) begin
                    resolve_s = 1'b1;
                end else begin
                    instr_valid_s = 1'b1;
                    instr_s       = buf_instr_r;
                    instr_pc_s    = buf_pc_r;
                    if (!stall_f) begin
                        pc_en_s = 1'b1;
                        state_s = S_REQ;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
            end
`ifdef PC_SEQ_MISALIGN_FAULT_EN
            S_FAULT: begin
                if (trap_valid) begin
                    pc_en_s  = 1'b1;
                    pc_new_s = trap_vector;
                    state_s  = S_REQ;
                end else begin
                    state_s = S_FAULT;
                end
            end
`endif
            default: state_s = S_BOOT;
        endcase
        // A resolved redirect drops any response/buffer and loads the target.
        if (resolve_s) begin
            pend_valid_s = 1'b0;
            pend_trap_s  = 1'b0;
`ifdef PC_SEQ_MISALIGN_FAULT_EN
            if (!eff_trap_s && (eff_target_s[1:0] != 2'b00)) begin
                misaligned_s = 1'b1;
                state_s      = S_FAULT;
            end else begin
                pc_en_s  = 1'b1;
                pc_new_s = eff_target_s;
                state_s  = S_REQ;
            end
`else
            pc_en_s  = 1'b1;
            pc_new_s = eff_target_s;
            state_s  = S_REQ;
`endif
        end else begin
            misaligned_s = misaligned_s;
        end
    end

    // Outputs are quiet while reset is held, except the reset vector on pc_new.
    always_comb begin
        if (reset) begin
            pc_en            = 1'b0;
            pc_new           = RESET_VECTOR;
            imem_req         = 1'b0;
            imem_addr        = {XLEN{1'b0}};
            instr_valid      = 1'b0;
            instr            = {XLEN{1'b0}};
            instr_pc         = {XLEN{1'b0}};
            fetch_misaligned = 1'b0;
        end else begin
            pc_en            = pc_en_s;
            pc_new           = pc_new_s;
            imem_req         = imem_req_s;
            imem_addr        = pc;
            instr_valid      = instr_valid_s;
            instr            = instr_s;
            instr_pc         = instr_pc_s;
            fetch_misaligned = misaligned_s;
        end
    end

    // State, pending-redirect and hold-buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_BOOT;
            pend_valid_r  <= 1'b0;
            pend_trap_r   <= 1'b0;
            pend_target_r <= {XLEN{1'b0}};
            buf_instr_r   <= {XLEN{1'b0}};
            buf_pc_r      <= {XLEN{1'b0}};
        end else begin
            state_r       <= state_s;
            pend_valid_r  <= pend_valid_s;
            pend_trap_r   <= pend_trap_s;
            pend_target_r <= pend_target_s;
            buf_instr_r   <= buf_instr_s;
            buf_pc_r      <= buf_pc_s;
        end
    end

endmodule
